// File: rtl/synth_bus_pkg.sv
// Shared types for the synth parameter bus arbiter: FSM states, owner codes,
// the bundled bus request record, and a width helper for the counters.
package synth_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_DEC = 2'd1,
    GNT_CPU = 2'd2,
    TAIL    = 2'd3
  } arb_state_t;

  localparam logic OWNER_DEC = 1'b0;
  localparam logic OWNER_CPU = 1'b1;

  typedef struct packed {
    logic [6:0] adr;
    logic [4:0] sel;
    logic       read;
    logic       write;
    logic       sysex_send;
  } bus_req_t;

  // Bits needed to count 0..value-1, never less than one bit.
  function automatic int clogb2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/param_bus_arbiter.sv
// Fair, timeout-protected arbiter for the synth parameter bus (decoder vs CPU).
// Grant one edge after request; bus_* are a 1-cycle registered copy of the owner's inputs.
module param_bus_arbiter
  import synth_bus_pkg::*;
#(
  parameter int TAIL_CYC = 5,
  parameter int MAX_HOLD = 64
) (
  input  logic       CLOCK_25,
  input  logic       reset_reg,
  input  logic       dec_req,
  input  logic [6:0] dec_adr,
  input  logic [4:0] dec_sel,
  input  logic       dec_read,
  input  logic       dec_write,
  input  logic       dec_sysex_send,
  input  logic       cpu_req,
  input  logic [6:0] cpu_adr,
  input  logic [4:0] cpu_sel,
  input  logic       cpu_read,
  input  logic       cpu_write,
  input  logic       cpu_sysex_send,
  output logic       dec_gnt,
  output logic       cpu_gnt,
  output logic [6:0] bus_adr,
  output logic [4:0] bus_sel,
  output logic       bus_read,
  output logic       bus_write,
  output logic       bus_sysex_send,
  output logic       bus_owner,
  output logic       bus_active,
  output logic       hold_timeout
);

  localparam int TAIL_W = clogb2(TAIL_CYC + 1);
  localparam int HOLD_W = clogb2(MAX_HOLD + 1);
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
  localparam bit TIMEOUT_EN = (MAX_HOLD != 0);

  arb_state_t        state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic              bus_owner_q, bus_owner_d;
  logic              dec_gnt_q, cpu_gnt_q;
  logic              active_q;
  logic              timeout_q, timeout_d;
  bus_req_t          bus_q, bus_d;
  logic [TAIL_W-1:0] tail_cnt_q, tail_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  bus_req_t dec_bus, cpu_bus, own_bus;
  logic     own_req, oth_req, hold_expired;

  assign dec_bus = '{adr: dec_adr, sel: dec_sel, read: dec_read,
                     write: dec_write, sysex_send: dec_sysex_send};
  assign cpu_bus = '{adr: cpu_adr, sel: cpu_sel, read: cpu_read,
                     write: cpu_write, sysex_send: cpu_sysex_send};

  assign own_req      = (state_q == GNT_DEC) ? dec_req : cpu_req;
  assign oth_req      = (state_q == GNT_DEC) ? cpu_req : dec_req;
  assign own_bus      = (state_q == GNT_DEC) ? dec_bus : cpu_bus;
  assign hold_expired = TIMEOUT_EN && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    bus_owner_d  = bus_owner_q;
    bus_d        = bus_q;
    tail_cnt_d   = tail_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    timeout_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie the side that did not own the bus last wins.
        if (dec_req && (!cpu_req || last_owner_q == OWNER_CPU)) begin
          state_d      = GNT_DEC;
          last_owner_d = OWNER_DEC;
          bus_owner_d  = OWNER_DEC;
          bus_d        = dec_bus;
          hold_cnt_d   = '0;
        end else if (cpu_req) begin
          state_d      = GNT_CPU;
          last_owner_d = OWNER_CPU;
          bus_owner_d  = OWNER_CPU;
          bus_d        = cpu_bus;
          hold_cnt_d   = '0;
        end
      end
      GNT_DEC, GNT_CPU: begin
        if (!own_req || (oth_req && hold_expired)) begin
          state_d          = TAIL;
          tail_cnt_d       = '0;
          bus_d.sel        = '0;
          bus_d.read       = 1'b0;
          bus_d.write      = 1'b0;
          bus_d.sysex_send = 1'b0;
          // A voluntary release in the expiry cycle is not a forced one.
          timeout_d        = own_req;
        end else begin
          bus_d = own_bus;
          if (hold_cnt_q != HOLD_SAT) hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      TAIL: begin
        if (tail_cnt_q == TAIL_LAST) state_d = IDLE;
        else                         tail_cnt_d = tail_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25 or posedge reset_reg) begin
    if (reset_reg) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_CPU;
      bus_owner_q  <= OWNER_DEC;
      dec_gnt_q    <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      active_q     <= 1'b0;
      timeout_q    <= 1'b0;
      bus_q        <= '0;
      tail_cnt_q   <= '0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      bus_owner_q  <= bus_owner_d;
      dec_gnt_q    <= (state_d == GNT_DEC);
      cpu_gnt_q    <= (state_d == GNT_CPU);
      active_q     <= (state_d != IDLE);
      timeout_q    <= timeout_d;
      bus_q        <= bus_d;
      tail_cnt_q   <= tail_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign dec_gnt        = dec_gnt_q;
  assign cpu_gnt        = cpu_gnt_q;
  assign bus_adr        = bus_q.adr;
  assign bus_sel        = bus_q.sel;
  assign bus_read       = bus_q.read;
  assign bus_write      = bus_q.write;
  assign bus_sysex_send = bus_q.sysex_send;
  assign bus_owner      = bus_owner_q;
  assign bus_active     = active_q;
  assign hold_timeout   = timeout_q;

  a_one_owner : assert property (@(posedge CLOCK_25) disable iff (reset_reg)
                                 !(dec_gnt && cpu_gnt));

endmodule
